// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU between two requesters.
// One operation in flight; operands/opcode are registered onto the ALU inputs and
// held for MULT_LAT cycles on a multiply so the ALU path can be multicycle.
// Optional feature macro: ALU_ARB_STATS_EN adds saturating grant/overflow counters.
module alu_arbiter #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MULT_LAT = 3,
  // {funct,type} encoding of {`MULT,`R_TYPE}; must match the ALU's opcodes.vh
  parameter logic [6:0]  MULT_OP  = 7'h18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [6:0]        req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [6:0]        req1_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [6:0]        alu_opcode,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [3:0]        alu_cc,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_out,
  output logic [3:0]        rsp_cc
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [15:0]       stat_grant0,
  output logic [15:0]       stat_grant1,
  output logic [15:0]       stat_ovf
`endif
);

  localparam int unsigned OP_W   = 7;
  localparam int unsigned CC_W   = 4;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned STAT_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                last_q, last_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   alu_a_q, alu_a_d;
  logic [DATA_W-1:0]   alu_b_q, alu_b_d;
  logic [OP_W-1:0]     alu_op_q, alu_op_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0]   rsp_out_q, rsp_out_d;
  logic [CC_W-1:0]     rsp_cc_q, rsp_cc_d;

  logic                grant0_c, grant1_c;
  logic                capture_c;
  logic [OP_W-1:0]     win_op_c;

  // Arbitration: only in IDLE and out of reset; ties go to the requester that did not win last
  always_comb begin
    grant0_c = 1'b0;
    grant1_c = 1'b0;
    if (!rst && state_q == IDLE) begin
      if (req0_valid && (!req1_valid || last_q)) begin
        grant0_c = 1'b1;
      end else if (req1_valid) begin
        grant1_c = 1'b1;
      end
    end
  end

  // Next-state and datapath update for the IDLE/EXEC/RESP sequence
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_out_d   = rsp_out_q;
    rsp_cc_d    = rsp_cc_q;
    capture_c   = 1'b0;
    win_op_c    = grant1_c ? req1_op : req0_op;
    case (state_q)
      IDLE: begin
        if (grant0_c || grant1_c) begin
          alu_a_d  = grant1_c ? req1_a : req0_a;
          alu_b_d  = grant1_c ? req1_b : req0_b;
          alu_op_d = win_op_c;
          rsp_id_d = grant1_c;
          last_d   = grant1_c;
          cnt_d    = (win_op_c == MULT_OP) ? CNT_W'(MULT_LAT - 1) : '0;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          capture_c   = 1'b1;
          rsp_out_d   = alu_out;
          rsp_cc_d    = alu_cc;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset drops any in-flight operation
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      cnt_q       <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_out_q   <= '0;
      rsp_cc_q    <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_out_q   <= rsp_out_d;
      rsp_cc_q    <= rsp_cc_d;
    end
  end

`ifdef ALU_ARB_STATS_EN
  logic [STAT_W-1:0] stat_g0_q, stat_g1_q, stat_ovf_q;

  // Saturating activity counters
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_g0_q  <= '0;
      stat_g1_q  <= '0;
      stat_ovf_q <= '0;
    end else begin
      if (grant0_c && stat_g0_q != '1) stat_g0_q <= stat_g0_q + STAT_W'(1);
      if (grant1_c && stat_g1_q != '1) stat_g1_q <= stat_g1_q + STAT_W'(1);
      if (capture_c && (alu_cc[1] || alu_cc[2]) && stat_ovf_q != '1)
        stat_ovf_q <= stat_ovf_q + STAT_W'(1);
    end
  end

  assign stat_grant0 = stat_g0_q;
  assign stat_grant1 = stat_g1_q;
  assign stat_ovf    = stat_ovf_q;
`endif

  assign req0_ready = grant0_c;
  assign req1_ready = grant1_c;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_opcode = alu_op_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_out    = rsp_out_q;
  assign rsp_cc     = rsp_cc_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed testbench for alu_arbiter with a small behavioural ALU attached.
module tb_alu_arbiter;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned MULT_LAT = 3;
  localparam logic [6:0]  OP_MULT  = 7'h18;
  localparam logic [6:0]  OP_ADD   = 7'h01;
  localparam logic [6:0]  OP_XOR   = 7'h11;

  logic              clk = 1'b0;
  logic              rst;
  logic              req0_valid, req0_ready;
  logic [DATA_W-1:0] req0_a, req0_b;
  logic [6:0]        req0_op;
  logic              req1_valid, req1_ready;
  logic [DATA_W-1:0] req1_a, req1_b;
  logic [6:0]        req1_op;
  logic [DATA_W-1:0] alu_a, alu_b, alu_out;
  logic [6:0]        alu_opcode;
  logic [3:0]        alu_cc;
  logic              rsp_valid, rsp_ready, rsp_id;
  logic [DATA_W-1:0] rsp_out;
  logic [3:0]        rsp_cc;
`ifdef ALU_ARB_STATS_EN
  logic [15:0]       stat_grant0, stat_grant1, stat_ovf;
`endif

  int checks = 0;
  int errors = 0;

  alu_arbiter #(.DATA_W(DATA_W), .MULT_LAT(MULT_LAT), .MULT_OP(OP_MULT)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_out(alu_out), .alu_cc(alu_cc),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_out(rsp_out), .rsp_cc(rsp_cc)
`ifdef ALU_ARB_STATS_EN
    , .stat_grant0(stat_grant0), .stat_grant1(stat_grant1), .stat_ovf(stat_ovf)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural ALU: ADD with signed overflow flag, MULT low word, otherwise XOR
  always_comb begin
    logic [DATA_W-1:0] sum;
    sum     = alu_a + alu_b;
    alu_out = alu_a ^ alu_b;
    alu_cc  = 4'b0000;
    if (alu_opcode == OP_ADD) begin
      alu_out   = sum;
      alu_cc[1] = (alu_a[31] == alu_b[31]) && (sum[31] != alu_a[31]);
    end else if (alu_opcode == OP_MULT) begin
      alu_out = alu_a * alu_b;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd2; req0_op = OP_ADD;
    req1_valid = 1'b1; req1_a = 32'd3; req1_b = 32'd4; req1_op = OP_ADD;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        errors++; $display("FAIL reset_ready got %b%b exp 00", req0_ready, req1_ready);
      end
      checks++;
      if (rsp_valid !== 1'b0 || rsp_out !== 32'd0) begin
        errors++; $display("FAIL reset_rsp got v=%b out=%h exp v=0 out=0", rsp_valid, rsp_out);
      end
      checks++;
      if (alu_opcode !== 7'd0) begin
        errors++; $display("FAIL reset_alu_opcode got %h exp 0", alu_opcode);
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst = 1'b0;
    step();
  endtask

  task automatic test_round_robin();
    int n_acc = 0;
    int last_cyc = 0;
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_op = OP_ADD; req0_a = 32'd10; req0_b = 32'd1;
    req1_valid = 1'b1; req1_op = OP_XOR; req1_a = 32'hF0; req1_b = 32'h0F;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (req0_ready || req1_ready) begin
        checks++;
        if (req0_ready && req1_ready) begin
          errors++; $display("FAIL rr_both_ready got 11 exp one-hot");
        end
        checks++;
        if (req1_ready !== ((n_acc % 2) == 1)) begin
          errors++; $display("FAIL rr_order accept %0d got id %b exp %0d", n_acc, req1_ready, n_acc % 2);
        end
        if (n_acc > 0) begin
          checks++;
          if (c - last_cyc != 3) begin
            errors++; $display("FAIL rr_interval got %0d exp 3", c - last_cyc);
          end
        end
        last_cyc = c;
        n_acc++;
      end
      step();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    checks++;
    if (n_acc != 4) begin
      errors++; $display("FAIL rr_accepts got %0d exp 4", n_acc);
    end
    step(); step();
  endtask

  task automatic test_add();
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd7; req0_op = OP_ADD;
    #1;
    checks++;
    if (req0_ready !== 1'b1) begin
      errors++; $display("FAIL add_ready got %b exp 1", req0_ready);
    end
    step();
    req0_valid = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++; $display("FAIL add_early_valid got %b exp 0 at N+1", rsp_valid);
    end
    step();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_out !== 32'd12 || rsp_id !== 1'b0) begin
      errors++; $display("FAIL add_rsp got v=%b out=%0d id=%b exp v=1 out=12 id=0", rsp_valid, rsp_out, rsp_id);
    end
    step();
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++; $display("FAIL add_rsp_drop got %b exp 0 at N+3", rsp_valid);
    end
  endtask

  task automatic test_mult();
    rsp_ready = 1'b1;
    req1_valid = 1'b1; req1_a = 32'd6; req1_b = 32'hFFFF_FFF9; req1_op = OP_MULT;
    #1;
    checks++;
    if (req1_ready !== 1'b1) begin
      errors++; $display("FAIL mult_ready got %b exp 1", req1_ready);
    end
    step();
    req1_valid = 1'b0; req1_a = 32'hDEAD; req1_b = 32'hBEEF; req1_op = OP_ADD;
    for (int k = 1; k <= 3; k++) begin
      checks++;
      if (alu_a !== 32'd6 || alu_b !== 32'hFFFF_FFF9 || alu_opcode !== OP_MULT || rsp_valid !== 1'b0) begin
        errors++;
        $display("FAIL mult_hold N+%0d got a=%h b=%h op=%h v=%b exp a=6 b=fffffff9 op=18 v=0", k, alu_a, alu_b, alu_opcode, rsp_valid);
      end
      step();
    end
    checks++;
    if (rsp_valid !== 1'b1 || rsp_out !== 32'hFFFF_FFD6 || rsp_id !== 1'b1) begin
      errors++; $display("FAIL mult_rsp got v=%b out=%h id=%b exp v=1 out=ffffffd6 id=1", rsp_valid, rsp_out, rsp_id);
    end
    step();
  endtask

  task automatic test_ovf_backpressure();
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 32'h7FFF_FFFF; req0_b = 32'd1; req0_op = OP_ADD;
    step();
    req0_valid = 1'b0;
    step();
    req0_valid = 1'b1; req1_valid = 1'b1; req1_op = OP_ADD;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_out !== 32'h8000_0000 || rsp_cc !== 4'b0010) begin
        errors++; $display("FAIL ovf_hold cyc %0d got v=%b out=%h cc=%b exp v=1 out=80000000 cc=0010", k, rsp_valid, rsp_out, rsp_cc);
      end
      checks++;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        errors++; $display("FAIL ovf_ready cyc %0d got %b%b exp 00", k, req0_ready, req1_ready);
      end
      step();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp_ready = 1'b1;
    step();
    checks++;
    if (rsp_valid !== 1'b0 || rsp_out !== 32'h8000_0000) begin
      errors++; $display("FAIL ovf_release got v=%b out=%h exp v=0 out=80000000", rsp_valid, rsp_out);
    end
  endtask

  task automatic test_reset_mid_mult();
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_a = 32'd3; req0_b = 32'd4; req0_op = OP_MULT;
    step();
    req0_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (alu_opcode !== 7'd0 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL midrst_state got op=%h v=%b exp op=0 v=0", alu_opcode, rsp_valid);
    end
`ifdef ALU_ARB_STATS_EN
    checks++;
    if (stat_grant0 !== 16'd0 || stat_grant1 !== 16'd0 || stat_ovf !== 16'd0) begin
      errors++; $display("FAIL midrst_stats got %h %h %h exp 0 0 0", stat_grant0, stat_grant1, stat_ovf);
    end
`endif
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (rsp_valid !== 1'b0) begin
        errors++; $display("FAIL midrst_ghost cyc %0d got v=1 exp 0", k);
      end
      step();
    end
    req0_valid = 1'b1; req0_a = 32'd2; req0_b = 32'd3; req0_op = OP_ADD;
    #1;
    checks++;
    if (req0_ready !== 1'b1) begin
      errors++; $display("FAIL midrst_ready got %b exp 1", req0_ready);
    end
    step();
    req0_valid = 1'b0;
    step();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_out !== 32'd5 || rsp_id !== 1'b0) begin
      errors++; $display("FAIL midrst_next got v=%b out=%0d id=%b exp v=1 out=5 id=0", rsp_valid, rsp_out, rsp_id);
    end
    step();
  endtask

  initial begin
    rst = 1'b1; rsp_ready = 1'b0;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0;
    test_reset();
    test_round_robin();
    test_add();
    test_mult();
    test_ovf_backpressure();
    test_reset_mid_mult();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
